// File: rtl/soc_addr_router_if.sv
// ============================================================================
// soc_addr_router_if: upstream master bus plus four-port slave fan-out.  Rev 1.0
// ============================================================================
`default_nettype none

interface soc_addr_router_if;
  logic         req_i;
  logic         gnt_o;
  logic [63:0]  addr_i;
  logic         we_i;
  logic [7:0]   be_i;
  logic [63:0]  wdata_i;
  logic         rvalid_o;
  logic [63:0]  rdata_o;
  logic         err_o;
  logic [3:0]   slv_req_o;
  logic [3:0]   slv_gnt_i;
  logic [63:0]  slv_addr_o;
  logic         slv_we_o;
  logic [7:0]   slv_be_o;
  logic [63:0]  slv_wdata_o;
  logic [3:0]   slv_rvalid_i;
  logic [255:0] slv_rdata_i;
  logic [3:0]   slv_err_i;

  // Router side
  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i,
    input  slv_gnt_i, slv_rvalid_i, slv_rdata_i, slv_err_i,
    output gnt_o, rvalid_o, rdata_o, err_o,
    output slv_req_o, slv_addr_o, slv_we_o, slv_be_o, slv_wdata_o
  );

  // Environment side: drives the upstream request and the slave responses
  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i,
    output slv_gnt_i, slv_rvalid_i, slv_rdata_i, slv_err_i,
    input  gnt_o, rvalid_o, rdata_o, err_o,
    input  slv_req_o, slv_addr_o, slv_we_o, slv_be_o, slv_wdata_o
  );
endinterface

`default_nettype wire

// File: rtl/soc_addr_router.sv
// ============================================================================
// soc_addr_router: single-outstanding address decoder/router to four slaves.
// Optional transfer timeout via SOC_ADDR_ROUTER_TIMEOUT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module soc_addr_router #(
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  soc_addr_router_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FWD  = 2'd1,
    S_WAIT = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [1:0] PORT_DRAM  = 2'd0;
  localparam logic [1:0] PORT_PERIP = 2'd1;
  localparam logic [1:0] PORT_CLINT = 2'd2;
  localparam logic [1:0] PORT_DEBUG = 2'd3;

  state_t      state;
  state_t      next_state;
  logic [1:0]  port;
  logic [63:0] addr;
  logic        we;
  logic [7:0]  be;
  logic [63:0] wdata;

  logic        dec_hit;
  logic [1:0]  dec_port;
  logic        timeout;

  logic        gnt;
  logic        rvalid;
  logic [63:0] rdata;
  logic        err;
  logic [3:0]  slv_req;

  if (TimeoutCycles < 2 || TimeoutCycles > 65535) begin : g_param_check
    $error("soc_addr_router: TimeoutCycles out of range 2..65535");
  end

  // Inclusive base / exclusive end windows; the upper address word must be zero.
  always_comb begin
    dec_hit  = 1'b0;
    dec_port = PORT_DRAM;
    if (bus.addr_i[63:32] == 32'h0) begin
      if (bus.addr_i[31:0] < 32'h0000_1000) begin
        dec_hit  = 1'b1;
        dec_port = PORT_DEBUG;
      end else if (bus.addr_i[31:0] >= 32'h0200_0000 && bus.addr_i[31:0] < 32'h020C_0000) begin
        dec_hit  = 1'b1;
        dec_port = PORT_CLINT;
      end else if (bus.addr_i[31:0] >= 32'h1000_0000 && bus.addr_i[31:0] < 32'h8000_0000) begin
        dec_hit  = 1'b1;
        dec_port = PORT_PERIP;
      end else if (bus.addr_i[31:0] >= 32'h8000_0000 && bus.addr_i[31:0] < 32'hC000_0000) begin
        dec_hit  = 1'b1;
        dec_port = PORT_DRAM;
      end
    end
  end

`ifdef SOC_ADDR_ROUTER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TimeoutCycles - 1);

  logic [15:0] cnt;

  // Held at zero while idle so it starts from zero on every entry to FWD.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= 16'h0;
    end else if (state == S_FWD || state == S_WAIT) begin
      cnt <= cnt + 16'h1;
    end else if (state == S_IDLE) begin
      cnt <= 16'h0;
    end
  end

  assign timeout = (cnt == TIMEOUT_LAST);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      port  <= 2'd0;
      addr  <= 64'h0;
      we    <= 1'b0;
      be    <= 8'h0;
      wdata <= 64'h0;
    end else begin
      state <= next_state;
      if (state == S_IDLE && bus.req_i) begin
        port  <= dec_port;
        addr  <= bus.addr_i;
        we    <= bus.we_i;
        be    <= bus.be_i;
        wdata <= bus.wdata_i;
      end
    end
  end

  always_comb begin
    next_state = state;
    gnt        = 1'b0;
    rvalid     = 1'b0;
    rdata      = 64'h0;
    err        = 1'b0;
    slv_req    = 4'b0000;
    case (state)
      S_IDLE: begin
        gnt = bus.req_i & ~rst_i;
        if (bus.req_i) begin
          next_state = dec_hit ? S_FWD : S_ERR;
        end
      end
      S_FWD: begin
        if (timeout) begin
          next_state = S_ERR;
        end else begin
          slv_req = 4'b0001 << port;
          if (bus.slv_gnt_i[port]) begin
            next_state = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // A response arriving in the timeout cycle still completes normally.
        if (bus.slv_rvalid_i[port]) begin
          rvalid     = 1'b1;
          err        = bus.slv_err_i[port];
          rdata      = (we || bus.slv_err_i[port]) ? 64'h0 : bus.slv_rdata_i[{port, 6'b0} +: 64];
          next_state = S_IDLE;
        end else if (timeout) begin
          next_state = S_ERR;
        end
      end
      S_ERR: begin
        rvalid     = 1'b1;
        err        = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  assign bus.gnt_o       = gnt;
  assign bus.rvalid_o    = rvalid;
  assign bus.rdata_o     = rdata;
  assign bus.err_o       = err;
  assign bus.slv_req_o   = slv_req;
  assign bus.slv_addr_o  = addr;
  assign bus.slv_we_o    = we;
  assign bus.slv_be_o    = be;
  assign bus.slv_wdata_o = wdata;

endmodule

`default_nettype wire
